// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// State encoding, fetch byte limit and default geometry.
package imem_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [15:0] IMEM_BYTE_LIMIT = 16'd32;
  localparam int          IMEM_ADDR_W     = 4;
  localparam int          IMEM_DATA_W     = 16;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: 2^ADDR_W words, synchronous write with clear-on-reset, async read.
// Write visible on the read port one edge later; no backpressure.
module imem_ram
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Loads a program over valid/ready into imem_ram, stalls the CPU while halted/loading, pulses pc_clear on release.
// Fetch is combinational; load_ready is a registered-state decode, high for the whole LOAD state.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_stall,
  output logic              pc_clear,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] WORDS = (ADDR_W+1)'(2**ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              loaded_q, loaded_d;
  logic              pc_clear_q, pc_clear_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              wr_hs, load_done;
  logic [DATA_W-1:0] ram_rdata;

  assign load_ready = (state_q == ST_LOAD);
  assign wr_hs      = load_valid & load_ready;
  // The 16th word ends the load even without load_last, so wr_ptr never wraps.
  assign load_done  = wr_hs & (load_last | (wr_ptr_q == '1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HALT;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      loaded_q     <= 1'b0;
      pc_clear_q   <= 1'b0;
      cpu_stall_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      loaded_q     <= loaded_d;
      pc_clear_q   <= pc_clear_d;
      cpu_stall_q  <= cpu_stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (load_start)   state_d = ST_LOAD;
        else if (run_req) state_d = ST_RUN;
      end
      ST_LOAD: if (load_done) state_d = ST_HALT;
      ST_RUN:  if (halt_req)  state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    loaded_d     = loaded_q;
    pc_clear_d   = (state_q == ST_HALT) && (state_d == ST_RUN);
    cpu_stall_d  = (state_d != ST_RUN);
    if ((state_q == ST_HALT) && load_start) begin
      wr_ptr_d     = '0;
      word_count_d = '0;
    end
    if (wr_hs) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (word_count_q != WORDS) word_count_d = word_count_q + (ADDR_W+1)'(1);
    end
    if (load_done) loaded_d = 1'b1;
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_hs),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (pc[ADDR_W:1]),
    .rdata (ram_rdata)
  );

  assign instruction = ((state_q == ST_RUN) && (pc < IMEM_BYTE_LIMIT)) ? ram_rdata : '0;
  assign cpu_stall   = cpu_stall_q;
  assign pc_clear    = pc_clear_q;
  assign loaded      = loaded_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed + randomized bench for imem_load_ctrl against a behavioural model of the load/run rules.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start, load_valid, load_last, load_ready;
  logic [15:0] load_data;
  logic        run_req, halt_req;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        cpu_stall, pc_clear, loaded;
  logic [4:0]  word_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .pc          (pc),
    .instruction (instruction),
    .cpu_stall   (cpu_stall),
    .pc_clear    (pc_clear),
    .loaded      (loaded),
    .word_count  (word_count)
  );

  // Behavioural reference: mode, program memory, load position and flags.
  localparam int M_HALT = 0, M_LOAD = 1, M_RUN = 2;
  int          m_mode;
  logic [15:0] m_mem [16];
  int          m_ptr, m_cnt;
  bit          m_loaded, m_pcclr;

  task automatic model_edge();
    if (reset) begin
      m_mode = M_HALT;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
      m_ptr = 0; m_cnt = 0; m_loaded = 0; m_pcclr = 0;
    end else begin
      m_pcclr = 0;
      if (m_mode == M_HALT) begin
        if (load_start) begin
          m_mode = M_LOAD; m_ptr = 0; m_cnt = 0;
        end else if (run_req) begin
          m_mode = M_RUN; m_pcclr = 1;
        end
      end else if (m_mode == M_LOAD) begin
        if (load_valid) begin
          m_mem[m_ptr] = load_data;
          m_ptr++;
          m_cnt++;
          if (load_last || m_ptr == 16) begin
            m_mode = M_HALT; m_loaded = 1;
          end
        end
      end else begin
        if (halt_req) m_mode = M_HALT;
      end
    end
  endtask

  function automatic logic [15:0] exp_instr();
    if (m_mode == M_RUN && pc < 16'd32) return m_mem[pc >> 1];
    return 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":instr"},  instruction, exp_instr());
    chk({tag, ":stall"},  cpu_stall,   m_mode != M_RUN);
    chk({tag, ":ready"},  load_ready,  m_mode == M_LOAD);
    chk({tag, ":pcclr"},  pc_clear,    m_pcclr);
    chk({tag, ":loaded"}, loaded,      m_loaded);
    chk({tag, ":wcnt"},   word_count,  m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic probe(input int v);
    pc = 16'(v);
    #1;
    check_all($sformatf("probe%0d", v));
  endtask

  // One loader word after 0..max_gap idle cycles; control inputs carry noise that LOAD must ignore.
  task automatic load_word(input logic [15:0] d, input bit last, input int max_gap);
    repeat ($urandom_range(0, max_gap)) begin
      load_valid = 0;
      load_last  = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      load_start = 1'($urandom_range(0, 1));
      run_req    = 1'($urandom_range(0, 1));
      halt_req   = 1'($urandom_range(0, 1));
      step("gap");
    end
    load_valid = 1; load_data = d; load_last = last;
    step("word");
    load_valid = 0; load_last = 0;
    load_start = 0; run_req = 0; halt_req = 0;
  endtask

  task automatic start_load();
    load_start = 1;
    step("start");
    load_start = 0;
  endtask

  task automatic run_cpu();
    run_req = 1;
    step("run");
    run_req = 0;
    chk("pcclr_pulse", pc_clear, 1);
    step("run2");
    chk("pcclr_drop", pc_clear, 0);
  endtask

  task automatic halt_cpu();
    halt_req = 1;
    step("halt");
    halt_req = 0;
    chk("halt_stall", cpu_stall, 1);
  endtask

  initial begin
    int n;
    reset = 1; load_start = 0; load_valid = 0; load_last = 0;
    load_data = 0; run_req = 0; halt_req = 0; pc = 0;
    step("rst0");
    step("rst1");
    reset = 0;
    step("idle");
    chk("rst_stall", cpu_stall, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_wcnt", word_count, 0);
    repeat (4) probe($urandom_range(0, 40));

    // Short load, then release
    start_load();
    chk("ready_rise", load_ready, 1);
    load_word(16'h8280, 0, 0);
    load_word(16'h353F, 0, 0);
    load_word(16'h8180, 1, 0);
    chk("short_wcnt", word_count, 3);
    chk("short_loaded", loaded, 1);
    chk("short_ready", load_ready, 0);
    run_cpu();
    probe(2);  chk("fetch_pc2", instruction, 16'h353F);
    probe(6);  chk("fetch_pc6", instruction, 16'h0000);
    probe(32); chk("fetch_pc32", instruction, 16'h0000);
    probe(0);  chk("fetch_pc0", instruction, 16'h8280);
    load_start = 1;
    step("start_in_run");
    load_start = 0;
    chk("run_ignores_start", cpu_stall, 0);
    halt_cpu();

    // Full load without load_last; load_start and run_req together pick LOAD
    load_start = 1; run_req = 1;
    step("prio");
    load_start = 0; run_req = 0;
    chk("prio_ready", load_ready, 1);
    chk("prio_pcclr", pc_clear, 0);
    for (int i = 0; i < 16; i++) load_word(16'h1000 + 16'(i), 0, 3);
    chk("full_ready", load_ready, 0);
    chk("full_wcnt", word_count, 16);
    load_valid = 1; load_data = 16'hDEAD;
    step("extra_valid");
    load_valid = 0;
    run_cpu();
    probe(30); chk("full_pc30", instruction, 16'h100F);
    probe(0);  chk("full_pc0", instruction, 16'h1000);
    repeat (4) probe($urandom_range(0, 40));
    halt_cpu();

    // Random programs of random length
    repeat (4) begin
      n = $urandom_range(1, 16);
      start_load();
      for (int i = 0; i < n; i++)
        load_word(16'($urandom), (i == n - 1) ? 1'b1 : 1'b0, 2);
      run_cpu();
      repeat (6) probe($urandom_range(0, 40));
      halt_cpu();
    end

    // Reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) load_word(16'($urandom) | 16'h1, 0, 1);
    reset = 1;
    step("midrst");
    reset = 0;
    chk("midrst_wcnt", word_count, 0);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_stall", cpu_stall, 1);
    run_cpu();
    for (int a = 0; a < 32; a += 2) begin
      probe(a);
      chk($sformatf("cleared_pc%0d", a), instruction, 16'h0000);
    end
    halt_cpu();
    start_load();
    for (int i = 0; i < 16; i++) load_word(16'($urandom), 0, 1);
    chk("reload_wcnt", word_count, 16);
    chk("reload_loaded", loaded, 1);
    run_cpu();
    for (int a = 0; a < 34; a += 2) probe(a);
    halt_cpu();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
